fpround_arbiter: RTL
====================

Name: fpround_arbiter

Overview:
- Shares one combinational FP rounder between two requesters: requester 0 is the add/sub normalise stage and requester 1 is the int/FP convert stage.
- Round-robin arbitration feeds a 2-stage pipeline. Stage S1 holds the issue register that drives the rounder inputs; stage S2 holds the result register that drives the consumer.
- Responses carry the requester ID. The block also keeps a sticky accumulator for IEEE exception flags.

Parameters:
PW, 96, request payload width. Bit layout MSB→LSB: rm[2:0], P, OvEn, UnEn, exp_valid, sel_inv[3:0], Invalid, DenormIn, convert, Asign, Aexp[10:0], norm_shift[5:0], A[63:0].
CNTW, 16, width of each performance counter (optional feature only).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  request valid, one bit per requester
req_ready  out  2  request accepted this cycle when valid & ready
req0_data  in  PW  requester 0 payload
req1_data  in  PW  requester 1 payload
rnd_data  out  PW  payload presented to the rounder (S1 contents)
rnd_result  in  64  rounder Result
rnd_flags  in  5  rounder Flags {UF,0,OF,NV,NX}
rnd_denorm  in  1  rounder DenormIO
rsp_valid  out  1  response valid (S2 occupied)
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester ID of response
rsp_result  out  64  rounded result
rsp_flags  out  5  flags for this op
rsp_denorm  out  1  DenormIO for this op
fflags_clr  in  1  clear sticky flags
fflags  out  5  sticky OR of flags of every response handed off

Behaviour:
- Reset (async on reset_n low, release sync to clk):
  - s1_v=0, s2_v=0, rr_ptr=0, fflags=0, rsp_valid=0, req_ready=0.
  - rnd_data=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_denorm=0.
- Advance conditions:
  - s2_adv = ~s2_v | rsp_ready.
  - s1_adv = ~s1_v | s2_adv. S1 loads a new request only when s1_adv.
- Arbitration (combinational, at most one grant per cycle):
  - Both valid: grant = rr_ptr.
  - Otherwise: grant goes to the single valid requester.
  - req_ready[i] = s1_adv & grant==i. Never assert both bits.
- rr_ptr update: on an accepted handshake, rr_ptr <= ~granted ID. Unchanged otherwise, including while stalled.
- S1 load:
  - On accept, S1 <= {id, payload} and s1_v <= 1.
  - If s1_adv with no accept, s1_v <= 0 and rnd_data holds its old value (don't care).
- S2 load:
  - When s2_adv & s1_v, S2 <= {S1 id, rnd_result, rnd_flags, rnd_denorm} and s2_v <= 1.
  - When s2_adv & ~s1_v, s2_v <= 0.
- Latency and throughput:
  - Accept in cycle N → rsp_valid in cycle N+2 with no backpressure.
  - Throughput 1 op/cycle.
  - Max 2 ops in flight.
- Backpressure:
  - rsp_valid & ~rsp_ready: S2 holds all outputs stable.
  - S1 holds if s1_v. req_ready=0 while both stages are full.
- Response handshake and flags:
  - On rsp_valid & rsp_ready: fflags <= fflags | rsp_flags.
  - fflags_clr takes priority over that OR in the same cycle: fflags <= 0, and the flags of a simultaneously handed-off op are dropped.
  - fflags bit 3 (DZ) is always 0 because rnd_flags[3] is 0.
- Ordering: responses are strictly in accept order.
- Payload integrity: no payload bit is modified.
- Mid-operation reset: in-flight ops are discarded with no response, and fflags are lost.

Optional Feature:
Macro FPROUND_ARB_PERF_EN.
- When defined, adds outputs:
  - perf_ops0 [CNTW-1:0]: accepted ops, requester 0.
  - perf_ops1 [CNTW-1:0]: accepted ops, requester 1.
  - perf_stall [CNTW-1:0]: cycles with rsp_valid & ~rsp_ready.
- All three counters reset to 0, saturate at all-ones and do not wrap. fflags_clr does not affect them.
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Single op: req0 valid, A=0x0000_0000_0000_0C00, P=0, rm=0, rounder model attached → rsp_valid 2 cycles later, rsp_id=0, rsp_result=model output, fflags updated on handoff.
- Contention: both requesters valid continuously, rsp_ready=1 → grants alternate 0,1,0,1 starting from 0 after reset; 8 responses with IDs 0,1,0,1,0,1,0,1.
- Backpressure: 3 back-to-back req1 ops, rsp_ready=0 for 5 cycles → req_ready drops after the 2nd accept; rsp outputs stable; 3rd op is accepted the cycle rsp_ready returns; order preserved.
- Flags: op with rnd_flags=5'b00001 then op with 5'b00100 → fflags=5'b00101. fflags_clr in the same cycle as a handoff of 5'b10000 → fflags=0.
- Reset mid-flight: assert reset_n low with s1_v=s2_v=1 → outputs zero immediately (async); after release, no stale rsp_valid, rr_ptr=0.
- FPROUND_ARB_PERF_EN: 4 req0 ops, 3 req1 ops, 2 stall cycles → perf_ops0=4, perf_ops1=3, perf_stall=2. Force saturation with CNTW=2 → counter holds at 3.

Source files
------------

// File: rtl/fpround_arbiter.sv
// Round-robin arbiter sharing one combinational FP rounder between add/sub (id 0) and convert (id 1).
// Optional macro FPROUND_ARB_PERF_EN adds saturating perf counters (perf_ops0, perf_ops1, perf_stall).
module fpround_arbiter #(
  parameter int PW   = 96,
  parameter int CNTW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [PW-1:0] req0_data,
  input  logic [PW-1:0] req1_data,
  output logic [PW-1:0] rnd_data,
  input  logic [63:0]   rnd_result,
  input  logic [4:0]    rnd_flags,
  input  logic          rnd_denorm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [63:0]   rsp_result,
  output logic [4:0]    rsp_flags,
  output logic          rsp_denorm,
  input  logic          fflags_clr,
  output logic [4:0]    fflags
`ifdef FPROUND_ARB_PERF_EN
  ,
  output logic [CNTW-1:0] perf_ops0,
  output logic [CNTW-1:0] perf_ops1,
  output logic [CNTW-1:0] perf_stall
`endif
);

  logic s1_v;
  logic s1_id;
  logic s2_v;
  logic rr_ptr;
  logic s1_adv;
  logic s2_adv;
  logic grant;
  logic accept;
  logic handoff;

  assign s2_adv  = ~s2_v | rsp_ready;
  assign s1_adv  = ~s1_v | s2_adv;
  assign grant   = (&req_valid) ? rr_ptr : req_valid[1];
  // Gating with reset_n keeps req_ready low for the whole time reset is asserted.
  assign accept  = (|req_valid) & s1_adv & reset_n;
  assign handoff = s2_v & rsp_ready;

  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = s2_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v       <= 1'b0;
      s1_id      <= 1'b0;
      s2_v       <= 1'b0;
      rr_ptr     <= 1'b0;
      rnd_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_denorm <= 1'b0;
      fflags     <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= ~grant;
      end
      if (s1_adv) begin
        s1_v <= accept;
        if (accept) begin
          s1_id    <= grant;
          rnd_data <= grant ? req1_data : req0_data;
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          rsp_id     <= s1_id;
          rsp_result <= rnd_result;
          rsp_flags  <= rnd_flags;
          rsp_denorm <= rnd_denorm;
        end
      end
      // A clear in the same cycle as a handoff drops that op's flags.
      if (fflags_clr) begin
        fflags <= '0;
      end else if (handoff) begin
        fflags <= fflags | rsp_flags;
      end
    end
  end

`ifdef FPROUND_ARB_PERF_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops0  <= '0;
      perf_ops1  <= '0;
      perf_stall <= '0;
    end else begin
      if (accept && !grant && perf_ops0 != CNT_MAX) begin
        perf_ops0 <= perf_ops0 + CNT_ONE;
      end
      if (accept && grant && perf_ops1 != CNT_MAX) begin
        perf_ops1 <= perf_ops1 + CNT_ONE;
      end
      if (s2_v && !rsp_ready && perf_stall != CNT_MAX) begin
        perf_stall <= perf_stall + CNT_ONE;
      end
    end
  end
`endif

endmodule
